// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters,
// each with a registered single-entry response slot.

module alu_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0][2:0]  req_op,
  input  logic [NUM_REQ-1:0][15:0] req_lhs,
  input  logic [NUM_REQ-1:0][15:0] req_rhs,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [NUM_REQ-1:0][15:0] rsp_result
);
  localparam int PW = (NUM_REQ > 2) ? 2 : 1;

  logic [PW-1:0]      ptr_q, ptr_d, gnt_idx, scan_idx;
  logic [NUM_REQ-1:0] elig, grant;
  logic               gnt_any;
  logic [2:0]         alu_op;
  logic [15:0]        alu_lhs, alu_rhs, alu_res;

  // A full slot may accept only when it drains in the same cycle.
  assign elig = req_valid & (~rsp_valid | rsp_ready);

  always_comb begin
    grant    = '0;
    gnt_any  = 1'b0;
    gnt_idx  = ptr_q;
    scan_idx = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (!gnt_any && elig[scan_idx]) begin
        gnt_any         = 1'b1;
        gnt_idx         = scan_idx;
        grant[scan_idx] = 1'b1;
      end
    end
    if (rst) begin
      grant   = '0;
      gnt_any = 1'b0;
    end
  end

  assign req_ready = grant;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = PW'((int'(gnt_idx) + 1) % NUM_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // With no grant gnt_idx falls back to ptr, so the ALU sees requester ptr.
  assign alu_op  = req_op[gnt_idx];
  assign alu_lhs = req_lhs[gnt_idx];
  assign alu_rhs = req_rhs[gnt_idx];

  ALU u_alu (
    .op     (alu_op),
    .lhs    (alu_lhs),
    .rhs    (alu_rhs),
    .result (alu_res)
  );

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    alu_arb_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .accept    (grant[i]),
      .drain     (rsp_ready[i]),
      .result_in (alu_res),
      .valid     (rsp_valid[i]),
      .result    (rsp_result[i])
    );
  end
endmodule

// Single-entry response slot; a new result wins over a same-cycle drain.
module alu_arb_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        accept,
  input  logic        drain,
  input  logic [15:0] result_in,
  output logic        valid,
  output logic [15:0] result
);
  logic        valid_q, valid_d;
  logic [15:0] result_q, result_d;

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    if (accept) begin
      valid_d  = 1'b1;
      result_d = result_in;
    end else if (drain) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign valid  = valid_q;
  assign result = result_q;
endmodule

// Shared combinational ALU on signed 16-bit operands.
module ALU (
  input  logic [2:0]  op,
  input  logic [15:0] lhs,
  input  logic [15:0] rhs,
  output logic [15:0] result
);
  always_comb begin
    result = '0;
    case (op)
      3'd0: result = lhs + rhs;
      3'd1: result = lhs - rhs;
      3'd2: result = lhs & rhs;
      3'd3: result = lhs ^ rhs;
      3'd4: result = lhs << rhs[3:0];
      3'd5: result = 16'($signed(lhs) >>> rhs[3:0]);
      3'd6: result = lhs | rhs;
      3'd7: result = {15'd0, $signed(lhs) < $signed(rhs)};
      default: result = '0;
    endcase
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a 2-requester and a 4-requester instance.

module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       v2, rdy2, rv2, rr2;
  logic [1:0][2:0]  op2;
  logic [1:0][15:0] lhs2, rhs2, res2;

  logic [3:0]       v4, rdy4, rv4, rr4;
  logic [3:0][2:0]  op4;
  logic [3:0][15:0] lhs4, rhs4, res4;

  int n_chk = 0;
  int n_err = 0;

  alu_arbiter #(.NUM_REQ(2)) d2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_op(op2),
    .req_lhs(lhs2), .req_rhs(rhs2), .rsp_valid(rv2), .rsp_ready(rr2),
    .rsp_result(res2)
  );

  alu_arbiter #(.NUM_REQ(4)) d4 (
    .clk(clk), .rst(rst), .req_valid(v4), .req_ready(rdy4), .req_op(op4),
    .req_lhs(lhs4), .req_rhs(rhs4), .rsp_valid(rv4), .rsp_ready(rr4),
    .rsp_result(res4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int seq[9];
    int resp;
    logic [3:0] oh;
    rst = 1'b1;
    v2 = '0; rr2 = '0; op2 = '0; lhs2 = '0; rhs2 = '0;
    v4 = '0; rr4 = '0; op4 = '0; lhs4 = '0; rhs4 = '0;

    // Reset state and no accept while in reset
    tick();
    v2 = 2'b11;
    #1 chk("rst_ready", rdy2, 2'b00);
    tick();
    rst = 1'b0;
    v2 = 2'b00;
    chk("rst_vld", rv2, 2'b00);
    chk("rst_res0", res2[0], 16'd0);
    chk("rst_res1", res2[1], 16'd0);

    // Single request
    v2 = 2'b01; op2[0] = 3'd6; lhs2[0] = 16'd12; rhs2[0] = 16'd3; rr2 = 2'b11;
    #1 chk("single_rdy", rdy2, 2'b01);
    tick();
    v2 = 2'b00;
    chk("single_vld", rv2, 2'b01);
    chk("single_res", res2[0], 16'd15);
    tick();
    chk("single_drain", rv2, 2'b00);

    // Contention: grants alternate 0,1,0,1
    do_reset();
    v2 = 2'b11; op2 = {3'd6, 3'd6};
    lhs2[0] = 16'd5; rhs2[0] = 16'd9; lhs2[1] = 16'd2; rhs2[1] = 16'd4;
    for (int k = 0; k < 4; k++) begin
      #1 chk("cont_rdy", rdy2, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk("cont_vld", rv2, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("cont_res", res2[k % 2], (k % 2 == 0) ? 16'd13 : 16'd6);
    end

    // Backpressure on slot 0 blocks only requester 0
    rr2 = 2'b10;
    #1 chk("bp_fill_rdy", rdy2, 2'b01);
    tick();
    lhs2[0] = 16'd1; rhs2[0] = 16'd16;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_rdy", rdy2, 2'b10);
      tick();
      chk("bp_vld0", rv2[0], 1'b1);
      chk("bp_hold0", res2[0], 16'd13);
      chk("bp_res1", res2[1], 16'd6);
    end
    rr2 = 2'b11;
    #1 chk("bp_release_rdy", rdy2, 2'b01);
    tick();
    chk("bp_reload_vld", rv2[0], 1'b1);
    chk("bp_reload_res", res2[0], 16'd17);

    // Reset mid-operation
    do_reset();
    v2 = 2'b11; rr2 = 2'b00;
    lhs2[0] = 16'd5; rhs2[0] = 16'd9; lhs2[1] = 16'd2; rhs2[1] = 16'd4;
    #1 chk("mid_g0", rdy2, 2'b01);
    tick();
    #1 chk("mid_g1", rdy2, 2'b10);
    tick();
    v2 = 2'b00;
    chk("mid_full", rv2, 2'b11);
    chk("mid_res0", res2[0], 16'd13);
    chk("mid_res1", res2[1], 16'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_vld", rv2, 2'b00);
    chk("mid_rst_res0", res2[0], 16'd0);
    chk("mid_rst_res1", res2[1], 16'd0);
    v2 = 2'b11; rr2 = 2'b11;
    #1 chk("mid_ptr0", rdy2, 2'b01);
    tick();
    v2 = 2'b00;

    // Sweep through port 1, one accept per cycle
    do_reset();
    v2 = 2'b10; rr2 = 2'b11; op2[1] = 3'd6;
    resp = 0;
    for (int l = 2; l <= 29; l++) begin
      for (int r = 2; r <= 29; r++) begin
        lhs2[1] = 16'(l); rhs2[1] = 16'(r);
        #1 chk("sweep_rdy", rdy2, 2'b10);
        tick();
        if (rv2[1]) resp++;
        chk("sweep_res", res2[1], 16'(l | r));
      end
    end
    v2 = 2'b00;
    chk("sweep_count", resp, 784);
    tick();
    chk("sweep_idle", rv2[1], 1'b0);

    // Four-way rotation, then requester 2 drops out
    do_reset();
    seq = '{0, 1, 2, 3, 0, 1, 3, 0, 1};
    v4 = 4'b1111; rr4 = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      op4[i] = 3'd6; lhs4[i] = 16'(i + 1); rhs4[i] = 16'(16 * (i + 1));
    end
    for (int k = 0; k < 9; k++) begin
      if (k == 5) v4[2] = 1'b0;
      oh = 4'(1 << seq[k]);
      #1 chk("rr4_rdy", rdy4, oh);
      tick();
      chk("rr4_vld", rv4, oh);
      chk("rr4_res", res4[seq[k]], 16'(17 * (seq[k] + 1)));
    end
    v4 = '0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `ALU` (3-bit `op`, signed 16-bit `lhs`/`rhs`, signed 16-bit `result`) between `NUM_REQ` requesters, e.g. the execute stage and the address-generation unit. It uses round-robin arbitration with valid/ready handshakes on both sides and a registered per-requester response slot. The block instantiates `ALU` internally and is the only driver of its inputs. Each requester sees a fixed one-cycle latency and full throughput when uncontended.

## Interface
Parameters:
- `NUM_REQ`, default 2, number of requesters; legal values 2–4.

Ports. Per-requester signals are packed `[NUM_REQ-1:0]` arrays, and index i belongs to requester i. Clock is `clk`, reset is `rst`: one clock, synchronous active-high reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  [NUM_REQ-1:0]  requester i presents an operation.
- `req_ready`  out  [NUM_REQ-1:0]  requester i's operation is accepted this cycle.
- `req_op`  in  [NUM_REQ-1:0][2:0]  ALU opcode (3'd6 = bitwise OR).
- `req_lhs`  in  [NUM_REQ-1:0][15:0]  signed left operand.
- `req_rhs`  in  [NUM_REQ-1:0][15:0]  signed right operand.
- `rsp_valid`  out  [NUM_REQ-1:0]  result slot i holds an unconsumed result.
- `rsp_ready`  in  [NUM_REQ-1:0]  requester i consumes slot i this cycle.
- `rsp_result`  out  [NUM_REQ-1:0][15:0]  signed result in slot i.

## Operation
- State:
  - round-robin pointer `ptr` in 0..NUM_REQ-1;
  - per-slot `rsp_valid` and `rsp_result` registers.
- Eligibility: `elig[i] = req_valid[i] && (!rsp_valid[i] || rsp_ready[i])`. A full slot is eligible only if it drains in the same cycle.
- Grant: the first eligible index scanning `ptr, ptr+1, …` modulo NUM_REQ. At most one grant per cycle. `req_ready` is one-hot or zero.
- `req_ready[i] = grant[i]`. This is combinational from `req_valid`, `rsp_valid`, `rsp_ready` and `ptr`. Requesters must not derive `req_valid` from `req_ready`.
- ALU inputs are muxed from the granted requester. With no grant they hold requester `ptr`'s inputs, and the value is unused.
- On accept of requester i (valid && ready): `rsp_result[i] <= ALU result`, `rsp_valid[i] <= 1`, `ptr <= (i+1) mod NUM_REQ`.
- With no accept, `ptr` is unchanged.
- Slot i without accept: if `rsp_ready[i]` then `rsp_valid[i] <= 0`. `rsp_result[i]` holds its value.
- Simultaneous drain and accept on slot i: the new result wins and `rsp_valid[i]` stays 1.
- `rsp_ready[i]` while `rsp_valid[i]=0` is ignored.
- Requester obligation: hold `req_op`/`req_lhs`/`req_rhs` stable while `req_valid && !req_ready`. `req_valid` must not drop before acceptance.
- Arithmetic: `rsp_result` is the ALU's 16-bit result, captured unmodified. No width extension or saturation is applied here.

## Timing
- Reset (`rst`=1 at an edge):
  - `rsp_valid` = 0;
  - `rsp_result` = 0;
  - `ptr` = 0.
- While `rst`=1, `req_ready` = 0 combinationally.
- Reset mid-operation discards pending results. Requests presented during reset are not accepted.
- Latency: accepted in cycle N, `rsp_valid[i]`=1 with result in cycle N+1.
- Throughput: one accept per cycle total. A single requester with `rsp_ready` held at 1 completes one operation every cycle.
- Fairness: with all NUM_REQ requesters continuously eligible, grants rotate strictly 0,1,…,NUM_REQ-1,0…. The worst-case wait is NUM_REQ-1 cycles.
- Backpressure on slot i (`rsp_valid[i]`=1, `rsp_ready[i]`=0) blocks only requester i. Other requesters are granted normally.

## Test plan
- **Single request:** after reset, req0 op=6 lhs=12 rhs=3, `rsp_ready`=all 1.
  - `req_ready[0]`=1 the same cycle.
  - Next cycle `rsp_valid[0]`=1, `rsp_result[0]`=15.
  - The following cycle `rsp_valid[0]`=0.
- **Contention, NUM_REQ=2:** both valid continuously from the first post-reset cycle, req0 5|9 and req1 2|4.
  - Grants go 0,1,0,1.
  - Results are 13 on slot 0 and 6 on slot 1, each one cycle after its grant.
- **Backpressure:** slot 0 full with `rsp_ready[0]`=0 while req0 and req1 are valid.
  - `req_ready[0]`=0 and req1 is granted every cycle.
  - Raise `rsp_ready[0]`: `req_ready[0]`=1 that cycle and slot 0 is reloaded, with `rsp_valid[0]` staying 1.
- **Reset mid-operation:** slots 0 and 1 hold 13 and 6 with `rsp_ready`=0. Pulse `rst` for 1 cycle.
  - Afterwards `rsp_valid`=0 and `rsp_result`=0.
  - The next simultaneous request grants req0 (ptr=0).
- **Sweep, NUM_REQ=2:** lhs,rhs each 2..29 at op=6 through port 1 only, `rsp_ready[1]`=1.
  - One accept per cycle.
  - Every result equals lhs|rhs.
  - 784 responses in 785 cycles.
- **Four-way rotation, NUM_REQ=4:** all four valid continuously.
  - Grant sequence is 0,1,2,3,0.
  - Drop req2's valid: the sequence continues 1,3,0,1 with no skipped eligible requester.
